// File: rtl/sound_sequencer_if.sv
// Request/status bundle between the game logic and the sound-effect sequencer.
//   start/sound            : one-cycle effect request and its code (master -> slave)
//   write_en/freq          : tone-generator drive (slave -> master)
//   busy/cur_sound         : playback status
//   done/dropped           : completion and rejected-request pulses
interface sound_sequencer_if #(
  parameter int FREQ_W = 20
);
  logic              start;
  logic [1:0]        sound;
  logic              write_en;
  logic [FREQ_W-1:0] freq;
  logic              busy;
  logic [1:0]        cur_sound;
  logic              done;
  logic              dropped;

  modport master (
    output start, sound,
    input  write_en, freq, busy, cur_sound, done, dropped
  );

  modport slave (
    input  start, sound,
    output write_en, freq, busy, cur_sound, done, dropped
  );
endinterface

// File: rtl/sound_sequencer.sv
// Multi-note sound-effect sequencer. Plays a fixed note table per effect code,
// each note held NOTE_CYCLES clocks with GAP_CYCLES silent clocks between
// notes. A request for a higher effect code preempts the running effect;
// lower/equal requests are dropped.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of sound_sequencer_if (request in, tone/status out)
// All outputs are flops loaded from the next-state values, so a start sampled
// at edge E is visible on the outputs in the cycle right after E.
module sound_sequencer #(
  parameter int FREQ_W      = 20,
  parameter int NOTE_CYCLES = 2097152,
  parameter int GAP_CYCLES  = 0
) (
  input  logic             clk,
  input  logic             reset,
  sound_sequencer_if.slave bus
);

  localparam int MAX_C = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] NOTE_END = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state, state_n;
  logic [1:0]       snd, snd_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done_n, drop_n;
  logic             note_end, last_note, load;

  function automatic logic [FREQ_W-1:0] note_freq(input logic [1:0] s, input logic [1:0] i);
    logic [9:0] f;
    case ({s, i})
      4'b00_00: f = 10'd523;
      4'b01_00: f = 10'd523;
      4'b01_01: f = 10'd262;
      4'b10_00: f = 10'd262;
      4'b10_01: f = 10'd523;
      4'b11_00: f = 10'd262;
      4'b11_01: f = 10'd196;
      4'b11_10: f = 10'd131;
      4'b11_11: f = 10'd65;
      default:  f = 10'd0;
    endcase
    return FREQ_W'(f);
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] s);
    case (s)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      2'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    snd_n     = snd;
    idx_n     = idx;
    cnt_n     = cnt;
    done_n    = 1'b0;
    drop_n    = 1'b0;
    load      = 1'b0;
    last_note = (idx == last_idx(snd));
    note_end  = (state == PLAY) && (cnt == NOTE_END);

    case (state)
      PLAY: begin
        if (note_end) begin
          cnt_n = '0;
          if (last_note) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_n = GAP;
          end else begin
            idx_n = idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_END) begin
          cnt_n   = '0;
          state_n = PLAY;
          idx_n   = idx + 2'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: ;
    endcase

    // A request landing on the final edge of the last note is treated as if
    // the sequencer were already idle, so back-to-back effects have no gap.
    if (bus.start) begin
      if (state == IDLE || (note_end && last_note) || bus.sound > snd)
        load = 1'b1;
      else
        drop_n = 1'b1;
    end

    if (load) begin
      state_n = PLAY;
      snd_n   = bus.sound;
      idx_n   = '0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      snd           <= '0;
      idx           <= '0;
      cnt           <= '0;
      bus.write_en  <= 1'b0;
      bus.freq      <= '0;
      bus.busy      <= 1'b0;
      bus.cur_sound <= '0;
      bus.done      <= 1'b0;
      bus.dropped   <= 1'b0;
    end else begin
      state         <= state_n;
      snd           <= snd_n;
      idx           <= idx_n;
      cnt           <= cnt_n;
      bus.write_en  <= (state_n == PLAY);
      bus.freq      <= (state_n == PLAY) ? note_freq(snd_n, idx_n) : '0;
      bus.busy      <= (state_n != IDLE);
      bus.cur_sound <= (state_n != IDLE) ? snd_n : 2'd0;
      bus.done      <= done_n;
      bus.dropped   <= drop_n;
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations into
// a queue; the monitor pops one entry per clock and compares the DUT outputs.
// DUT a: NOTE_CYCLES=8, GAP_CYCLES=2. DUT b: NOTE_CYCLES=8, GAP_CYCLES=0.
module tb_sound_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sound_sequencer_if #(.FREQ_W(20)) bus_a ();
  sound_sequencer_if #(.FREQ_W(20)) bus_b ();

  sound_sequencer #(.FREQ_W(20), .NOTE_CYCLES(8), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  sound_sequencer #(.FREQ_W(20), .NOTE_CYCLES(8), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  typedef struct {
    int          dut;
    logic        we;
    logic [19:0] freq;
    logic        busy;
    logic [1:0]  cur;
    logic        done;
    logic        drop;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic push(input int d, input int n, input logic we, input int f,
                      input logic busy, input int cur, input logic done,
                      input logic drop, input string nm);
    exp_t e;
    e.dut = d; e.we = we; e.freq = 20'(f); e.busy = busy; e.cur = 2'(cur);
    e.done = done; e.drop = drop; e.name = nm;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // helpers for the common record shapes
  task automatic note(input int d, input int n, input int f, input int cur, input string nm);
    push(d, n, 1'b1, f, 1'b1, cur, 1'b0, 1'b0, nm);
  endtask
  task automatic gap(input int d, input int cur, input string nm);
    push(d, 2, 1'b0, 0, 1'b1, cur, 1'b0, 1'b0, nm);
  endtask
  task automatic fin(input int d, input string nm);
    push(d, 1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, nm);
    push(d, 1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, nm);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain_timeout: %0d expectations left, required 0", q.size());
      failures++;
      q.delete();
    end
  endtask

  task automatic fire(input int d, input logic [1:0] s);
    if (d == 0) begin bus_a.start = 1'b1; bus_a.sound = s; end
    else        begin bus_b.start = 1'b1; bus_b.sound = s; end
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  // monitor
  exp_t r;
  logic        m_we, m_busy, m_done, m_drop;
  logic [19:0] m_freq;
  logic [1:0]  m_cur;
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      r = q.pop_front();
      if (r.dut == 0) begin
        m_we = bus_a.write_en; m_freq = bus_a.freq; m_busy = bus_a.busy;
        m_cur = bus_a.cur_sound; m_done = bus_a.done; m_drop = bus_a.dropped;
      end else begin
        m_we = bus_b.write_en; m_freq = bus_b.freq; m_busy = bus_b.busy;
        m_cur = bus_b.cur_sound; m_done = bus_b.done; m_drop = bus_b.dropped;
      end
      checks++;
      if (m_we !== r.we || m_freq !== r.freq || m_busy !== r.busy ||
          m_cur !== r.cur || m_done !== r.done || m_drop !== r.drop) begin
        failures++;
        $display("FAIL %s t=%0t: got we=%0b freq=%0d busy=%0b cur=%0d done=%0b drop=%0b, want we=%0b freq=%0d busy=%0b cur=%0d done=%0b drop=%0b",
                 r.name, $time, m_we, m_freq, m_busy, m_cur, m_done, m_drop,
                 r.we, r.freq, r.busy, r.cur, r.done, r.drop);
      end
    end
  end

  initial begin
    bus_a.start = 1'b0; bus_a.sound = 2'd0;
    bus_b.start = 1'b0; bus_b.sound = 2'd0;
    repeat (3) @(negedge clk);
    push(0, 1, 0, 0, 0, 0, 0, 0, "reset_a");
    push(1, 1, 0, 0, 0, 0, 0, 0, "reset_b");
    drain();
    reset = 1'b0;
    push(0, 2, 0, 0, 0, 0, 0, 0, "idle_a");
    drain();

    // 1: single-note key click
    note(0, 8, 523, 0, "t1_note");
    fin(0, "t1_done");
    fire(0, 2'd0);
    drain();

    // 2: four-note game-lost with gaps
    note(0, 8, 262, 3, "t2_n0"); gap(0, 3, "t2_g0");
    note(0, 8, 196, 3, "t2_n1"); gap(0, 3, "t2_g1");
    note(0, 8, 131, 3, "t2_n2"); gap(0, 3, "t2_g2");
    note(0, 8, 65, 3, "t2_n3");
    fin(0, "t2_done");
    fire(0, 2'd3);
    drain();

    // 3: land preempted by row clear during its 3rd cycle
    note(0, 3, 523, 1, "t3_land");
    fire(0, 2'd1);
    drain();
    note(0, 8, 262, 2, "t3_n0"); gap(0, 2, "t3_g0");
    note(0, 8, 523, 2, "t3_n1");
    fin(0, "t3_done");
    fire(0, 2'd2);
    drain();

    // 4: lower request mid-note and equal request mid-gap are both dropped
    note(0, 5, 262, 3, "t4_n0a");
    fire(0, 2'd3);
    drain();
    push(0, 1, 1, 262, 1, 3, 0, 1, "t4_drop_low");
    note(0, 2, 262, 3, "t4_n0b");
    push(0, 1, 0, 0, 1, 3, 0, 0, "t4_g0a");
    fire(0, 2'd0);
    drain();
    push(0, 1, 0, 0, 1, 3, 0, 1, "t4_drop_eq");
    note(0, 8, 196, 3, "t4_n1"); gap(0, 3, "t4_g1");
    note(0, 8, 131, 3, "t4_n2"); gap(0, 3, "t4_g2");
    note(0, 8, 65, 3, "t4_n3");
    fin(0, "t4_done");
    fire(0, 2'd3);
    drain();

    // 5: reset mid-note; start in the reset cycle is ignored
    note(0, 3, 262, 2, "t5_play");
    fire(0, 2'd2);
    drain();
    push(0, 1, 0, 0, 0, 0, 0, 0, "t5_reset");
    push(0, 2, 0, 0, 0, 0, 0, 0, "t5_idle");
    reset = 1'b1;
    bus_a.start = 1'b1; bus_a.sound = 2'd3;
    @(negedge clk);
    reset = 1'b0;
    bus_a.start = 1'b0;
    drain();

    // 6: no gap; new start on the final edge chains with zero idle cycles
    note(1, 8, 523, 1, "t6_n0");
    note(1, 8, 262, 1, "t6_n1");
    fire(1, 2'd1);
    drain();
    push(1, 1, 1, 523, 1, 0, 1, 0, "t6_chain");
    note(1, 7, 523, 0, "t6_key");
    fin(1, "t6_done");
    fire(1, 2'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
